// File: rtl/irq_ctrl.sv
// Machine-mode interrupt sequencer in front of the CSR file: interrupt entry (EPC save, vector redirect, flush) and mret return.
// Define IRQ_CTRL_SYNC_EN to pass irq_i through a SYNC_STAGES-deep synchronizer; undefined feeds it straight to edge detect.
module irq_ctrl #(
  parameter logic [31:0] IRQ_VECTOR  = 32'h0000_0010,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_i,
  input  logic        interrupt_enable_i,
  input  logic [31:0] epc_i,
  input  logic        instr_valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        mret_i,
  output logic        save_epc_o,
  output logic [31:0] pc_o,
  output logic        pc_set_o,
  output logic [31:0] pc_target_o,
  output logic        flush_o,
  output logic        irq_ack_o,
  output logic        mret_o,
  output logic        in_handler_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TAKE,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t      state;
  logic        irq_s;
  logic        irq_d;
  logic        pending;
  logic [31:0] pc_q;
  logic        boundary;
  logic        mret_now;
  logic        go_ret;
  logic        go_take;

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("irq_ctrl: SYNC_STAGES must be at least 2");
  end

`ifdef IRQ_CTRL_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];
`else
  assign irq_s = irq_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d <= 1'b0;
    end else begin
      irq_d <= irq_s;
    end
  end

  assign boundary = instr_valid_i & ~stall_i;
  assign mret_now = boundary & mret_i;

  // mret wins over entry; TAKE and RETURN themselves ignore a retiring mret.
  assign go_ret  = mret_now & ((state == S_IDLE) | (state == S_ARM) | (state == S_HANDLER));
  assign go_take = (state == S_ARM) & ~mret_now & interrupt_enable_i & boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pending      <= 1'b0;
      pc_q         <= '0;
      save_epc_o   <= 1'b0;
      pc_set_o     <= 1'b0;
      flush_o      <= 1'b0;
      irq_ack_o    <= 1'b0;
      mret_o       <= 1'b0;
      in_handler_o <= 1'b0;
    end else begin
      // A new rising edge in the clearing cycle still leaves the request pending.
      pending      <= (irq_s & ~irq_d) | (pending & (state != S_TAKE));
      save_epc_o   <= go_take;
      irq_ack_o    <= go_take;
      pc_set_o     <= go_take | go_ret;
      flush_o      <= go_take | go_ret;
      mret_o       <= go_ret;
      in_handler_o <= (state == S_TAKE) | ((state == S_HANDLER) & ~go_ret);
      if (go_take) begin
        pc_q <= pc_i;
      end
      unique case (state)
        S_IDLE: begin
          if (go_ret) begin
            state <= S_RETURN;
          end else if (pending & interrupt_enable_i) begin
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (go_ret) begin
            state <= S_RETURN;
          end else if (!interrupt_enable_i) begin
            state <= S_IDLE;
          end else if (go_take) begin
            state <= S_TAKE;
          end
        end
        S_TAKE: state <= S_HANDLER;
        S_HANDLER: begin
          if (go_ret) begin
            state <= S_RETURN;
          end
        end
        S_RETURN: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign pc_o = pc_q;

  always_comb begin
    pc_target_o = '0;
    if (state == S_TAKE) begin
      pc_target_o = IRQ_VECTOR;
    end else if (state == S_RETURN) begin
      pc_target_o = epc_i;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: cycle-level reference model compared every cycle, plus hand-computed checkpoints.
module tb_irq_ctrl;

  localparam int SYNC = 2;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = SYNC + 1;
`else
  localparam int LAT = 1;
`endif
  localparam int ENTRY = LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_i, interrupt_enable_i, instr_valid_i, stall_i, mret_i;
  logic [31:0] epc_i, pc_i;
  logic        save_epc_o, pc_set_o, flush_o, irq_ack_o, mret_o, in_handler_o;
  logic [31:0] pc_o, pc_target_o;

  int checks = 0;
  int errors = 0;
  int acks   = 0;
  int a0;

  irq_ctrl #(.IRQ_VECTOR(32'h0000_0010), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .interrupt_enable_i(interrupt_enable_i),
    .epc_i(epc_i), .instr_valid_i(instr_valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .mret_i(mret_i), .save_epc_o(save_epc_o), .pc_o(pc_o), .pc_set_o(pc_set_o),
    .pc_target_o(pc_target_o), .flush_o(flush_o), .irq_ack_o(irq_ack_o),
    .mret_o(mret_o), .in_handler_o(in_handler_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: history of sampled irq_i values, a pending flag and a sequence phase.
  localparam int M_IDLE = 0, M_ARM = 1, M_TAKE = 2, M_HAND = 3, M_RET = 4;
  int          m_mode;
  logic [7:0]  m_hist;
  logic        m_pend;
  logic [31:0] m_pcq;
  logic        m_s, m_dd, m_bnd;

`ifdef IRQ_CTRL_SYNC_EN
  assign m_s  = m_hist[SYNC-1];
  assign m_dd = m_hist[SYNC];
`else
  assign m_s  = irq_i;
  assign m_dd = m_hist[0];
`endif
  assign m_bnd = instr_valid_i & ~stall_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE;
      m_hist <= '0;
      m_pend <= 1'b0;
      m_pcq  <= '0;
    end else begin
      m_hist <= {m_hist[6:0], irq_i};
      m_pend <= (m_s & ~m_dd) | (m_pend & (m_mode != M_TAKE));
      case (m_mode)
        M_IDLE: if (m_bnd && mret_i) m_mode <= M_RET;
                else if (m_pend && interrupt_enable_i) m_mode <= M_ARM;
        M_ARM: begin
          if (m_bnd && mret_i) m_mode <= M_RET;
          else if (!interrupt_enable_i) m_mode <= M_IDLE;
          else if (m_bnd) begin
            m_mode <= M_TAKE;
            m_pcq  <= pc_i;
          end
        end
        M_TAKE: m_mode <= M_HAND;
        M_HAND: if (m_bnd && mret_i) m_mode <= M_RET;
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic tk, rt;
    tk = (m_mode == M_TAKE);
    rt = (m_mode == M_RET);
    cmp("model_save_epc", {31'd0, save_epc_o}, {31'd0, tk});
    cmp("model_irq_ack", {31'd0, irq_ack_o}, {31'd0, tk});
    cmp("model_pc_set", {31'd0, pc_set_o}, {31'd0, tk | rt});
    cmp("model_flush", {31'd0, flush_o}, {31'd0, tk | rt});
    cmp("model_mret", {31'd0, mret_o}, {31'd0, rt});
    cmp("model_in_handler", {31'd0, in_handler_o}, {31'd0, m_mode == M_HAND});
    cmp("model_pc_o", pc_o, m_pcq);
    cmp("model_pc_target", pc_target_o, tk ? 32'h10 : (rt ? epc_i : 32'd0));
    if (rst_n && irq_ack_o) acks++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_handler();
    step();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; irq_i = 1'b0; interrupt_enable_i = 1'b0; instr_valid_i = 1'b0;
    stall_i = 1'b0; mret_i = 1'b0; epc_i = 32'h0000_0204; pc_i = 32'h0000_0200;
    #3;
    cmp("reset_strobes", {26'd0, save_epc_o, pc_set_o, flush_o, irq_ack_o, mret_o, in_handler_o}, 32'd0);
    cmp("reset_pc_o", pc_o, 32'd0);
    cmp("reset_pc_target", pc_target_o, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Basic entry
    interrupt_enable_i = 1'b1; instr_valid_i = 1'b1;
    step();
    irq_i = 1'b1;
    repeat (ENTRY - 1) step();
    cmp("entry_not_early", {31'd0, save_epc_o}, 32'd0);
    step();
    cmp("entry_save_epc", {31'd0, save_epc_o}, 32'd1);
    cmp("entry_pc_o", pc_o, 32'h0000_0200);
    cmp("entry_pc_target", pc_target_o, 32'h0000_0010);
    cmp("entry_flush_ack", {30'd0, flush_o, irq_ack_o}, 32'd3);
    step();
    irq_i = 1'b0;
    cmp("entry_in_handler", {31'd0, in_handler_o}, 32'd1);
    cmp("entry_pulse_width", {31'd0, save_epc_o}, 32'd0);

    // Return
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    cmp("ret_strobes", {30'd0, pc_set_o, mret_o}, 32'd3);
    cmp("ret_pc_target", pc_target_o, 32'h0000_0204);
    step();
    cmp("ret_idle", {29'd0, pc_set_o, mret_o, in_handler_o}, 32'd0);

    // Masked request
    interrupt_enable_i = 1'b0;
    a0 = acks;
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    repeat (10) step();
    cmp("masked_no_take", acks, a0);
    pc_i = 32'h0000_0300;
    interrupt_enable_i = 1'b1;
    step();
    cmp("masked_arm", {31'd0, save_epc_o}, 32'd0);
    step();
    cmp("masked_take", {31'd0, save_epc_o}, 32'd1);
    cmp("masked_pc_o", pc_o, 32'h0000_0300);
    finish_handler();

    // Stalled entry
    stall_i = 1'b1;
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      cmp("stall_no_take", {31'd0, save_epc_o}, 32'd0);
    end
    pc_i = 32'h0000_0400;
    stall_i = 1'b0;
    step();
    cmp("stall_take", {31'd0, save_epc_o}, 32'd1);
    cmp("stall_pc_o", pc_o, 32'h0000_0400);
    finish_handler();

    // Simultaneous mret and pending entry while armed
    stall_i = 1'b1;
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    repeat (LAT + 1) step();
    stall_i = 1'b0;
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    cmp("simul_ret", {30'd0, mret_o, save_epc_o}, 32'd2);
    cmp("simul_target", pc_target_o, 32'h0000_0204);
    repeat (2) step();
    cmp("simul_rearm", {31'd0, save_epc_o}, 32'd0);
    step();
    cmp("simul_pending_kept", {31'd0, save_epc_o}, 32'd1);
    finish_handler();

    // Reset during TAKE
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    repeat (LAT + 1) step();
    cmp("rst_take_reached", {31'd0, save_epc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    cmp("rst_take_strobes", {26'd0, save_epc_o, pc_set_o, flush_o, irq_ack_o, mret_o, in_handler_o}, 32'd0);
    cmp("rst_take_pc", pc_o | pc_target_o, 32'd0);
    #2;
    rst_n = 1'b1;
    a0 = acks;
    repeat (8) step();
    cmp("rst_pending_clear", acks, a0);

    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
